uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter, the transmit-side counterpart of the UART receive path. Accepts a parallel byte over a valid/ready handshake and serialises it LSB-first on `tx`. Frame: start bit, DATA_BITS data bits, optional parity bit, STOP_BITS stop bits. Framing, bit order and parity sense match the receiver, so `tx` can loop straight into the Rx for self-test.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal ≥ 2
- DATA_BITS, 8, data bits per frame; legal 5–8
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with UART_TX_PARITY_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_valid  in  1  tx_data holds a byte to send
- tx_data  in  DATA_BITS  byte to send, sampled on accept
- tx_ready  out  1  block can accept a byte (IDLE only)
- tx  out  1  serial line, idle high, registered
- tx_busy  out  1  frame in progress (any state except IDLE)
- tx_done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: state = IDLE, tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0. The bit counter, bit index and shift register are all cleared.
- States:
  - IDLE → START on accept.
  - START → DATA.
  - DATA → PARITY (if enabled) or STOP.
  - PARITY → STOP.
  - STOP → IDLE.
  - Any unused encoding → IDLE.
- Accept: occurs on a clk edge where tx_valid & tx_ready. tx_data is latched into the shift register and the parity bit is computed at that edge.
- tx_data may change after accept with no effect on the frame in flight.
- tx_valid while tx_ready = 0 is ignored. It does not queue and does not corrupt the current frame.
- Latency: tx falls to 0 at the edge after accept (first start-bit cycle).
- Each bit lasts exactly CLKS_PER_BIT cycles. The counter runs 0..CLKS_PER_BIT-1 and advances state or bit index at terminal count.
- DATA state: sends bit 0 first, bit DATA_BITS-1 last. The bit index wraps at DATA_BITS-1.
- Parity bit: XOR of the latched data, inverted when PARITY_ODD = 1.
- STOP state: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
- Frame end: at STOP terminal count the block moves to IDLE. tx_done = 1 for exactly the first IDLE cycle; tx_ready = 1 in that same cycle.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 with parity enabled, else 0.
- Back-to-back: with tx_valid held high, the next byte is accepted in the tx_done cycle. The gap between the last stop bit and the next start bit is exactly one cycle of tx = 1.
- tx_busy equals !tx_ready.
- Reset mid-frame: next edge gives tx = 1 and IDLE; the partial frame is abandoned and no tx_done is issued.
- tx is driven from a flop only, so it is glitch-free.

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state and parity bit are inserted between the last data bit and the first stop bit, using the PARITY_ODD sense.
- Undefined: the PARITY state, parity flop and logic are compiled out. DATA → STOP directly, P = 0, and PARITY_ODD is ignored.

Test Plan:
All scenarios use CLKS_PER_BIT = 4, DATA_BITS = 8, STOP_BITS = 1.
1. No parity, send 0xA5 → tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1. tx_done pulses at cycle 41 after accept; tx_ready is low for cycles 1–40.
2. UART_TX_PARITY_EN, PARITY_ODD = 0:
   - send 0x07 → parity bit 1, frame 44 cycles;
   - send 0x03 → parity bit 0.
   With PARITY_ODD = 1, send 0x03 → parity bit 1.
3. Back-to-back: tx_valid held high with 0x55 then 0xFF → both frames are intact, with exactly one cycle of tx = 1 between the stop of the first frame and the start of the second. Exactly two tx_done pulses.
4. Change tx_data and toggle tx_valid during a 0x3C frame → serialised bits remain those of 0x3C, and no second frame starts until tx_ready.
5. Assert reset for 1 cycle at cycle 15 of a frame → next cycle tx = 1, tx_ready = 1, no tx_done. A subsequent 0x81 is sent correctly.
6. Loopback into the Rx path with STOP_BITS = 2 and parity enabled, bytes 0x00, 0xFF, 0x5A → the receiver stores all three with no parity or stop-bit error.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART serialiser fed by a valid/ready byte handshake.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_accept;
  logic w_bit_end;

  assign w_accept  = tx_valid & r_ready;
  assign w_bit_end = (r_cnt == CNT_LAST);

  // r_idx counts data bits in DATA and stop bits in STOP; r_shift drains LSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_START;
            r_shift  <= tx_data;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_tx     <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_idx == DATA_LAST) begin
              r_idx   <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            if (r_idx == STOP_LAST) begin
              r_state <= S_IDLE;
              r_idx   <= '0;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  localparam int FRAME0 = (1 + 8 + PEN + 1) * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic rdy0, tx0, busy0, done0;
  logic rdy1, tx1, busy1, done1;

  int errors = 0;
  int checks = 0;

  logic [127:0] c_tx, c_rdy, c_done, c_busy;
  logic [127:0] e_tx, e_rdy, e_done;
  int e_n;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .reset(reset), .tx_valid(v0), .tx_data(d0),
    .tx_ready(rdy0), .tx(tx0), .tx_busy(busy0), .tx_done(done0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_valid(v1), .tx_data(d1),
    .tx_ready(rdy1), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
  );

  // Reference model: expected per-cycle tx/ready/done, index 0 = first cycle after accept.
  function automatic void exp_clear();
    e_tx = '0; e_rdy = '0; e_done = '0; e_n = 0;
  endfunction

  function automatic void exp_cell(input logic val, input logic rdy, input logic dn, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      e_tx[e_n] = val; e_rdy[e_n] = rdy; e_done[e_n] = dn; e_n++;
    end
  endfunction

  function automatic void exp_frame(input logic [7:0] d, input int stops, input logic odd);
    exp_cell(1'b0, 1'b0, 1'b0, CPB);
    for (int b = 0; b < 8; b++) exp_cell(d[b], 1'b0, 1'b0, CPB);
    if (PEN == 1) exp_cell((^d) ^ odd, 1'b0, 1'b0, CPB);
    exp_cell(1'b1, 1'b0, 1'b0, stops * CPB);
    exp_cell(1'b1, 1'b1, 1'b1, 1);
  endfunction

  function automatic void exp_idle(input int n);
    exp_cell(1'b1, 1'b1, 1'b0, n);
  endfunction

  // Sample n cycles; optionally scramble valid/data, swap data after accept, drop valid.
  task automatic capture(input int sel, input int n, input int drop_at,
                         input logic [7:0] d2, input int chaos_upto);
    c_tx = '0; c_rdy = '0; c_done = '0; c_busy = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c_tx[i]   = (sel == 0) ? tx0   : tx1;
      c_rdy[i]  = (sel == 0) ? rdy0  : rdy1;
      c_done[i] = (sel == 0) ? done0 : done1;
      c_busy[i] = (sel == 0) ? busy0 : busy1;
      if (i < chaos_upto) begin
        v0 = 1'($urandom);
        d0 = 8'($urandom);
      end else begin
        if (i == 0) begin
          if (sel == 0) d0 = d2; else d1 = d2;
        end
        if (i >= drop_at) begin
          if (sel == 0) v0 = 1'b0; else v1 = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx0, rdy0, busy0, done0} !== 4'b1100) begin
      errors++; $display("FAIL reset_dut0 got=%b exp=1100", {tx0, rdy0, busy0, done0});
    end
    checks++;
    if ({tx1, rdy1, busy1, done1} !== 4'b1100) begin
      errors++; $display("FAIL reset_dut1 got=%b exp=1100", {tx1, rdy1, busy1, done1});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx0, rdy0, busy0, done0} !== 4'b1100) begin
      errors++; $display("FAIL idle_after_reset got=%b exp=1100", {tx0, rdy0, busy0, done0});
    end
  endtask

  task automatic test_basic();
    logic [127:0] m;
    logic [8:0] cells;
    exp_clear(); exp_frame(8'hA5, 1, 1'b0); exp_idle(3);
    m = (128'd1 << e_n) - 128'd1;
    d0 = 8'hA5; v0 = 1'b1;
    capture(0, e_n, 1, 8'hA5, 0);
    checks++; if (c_tx !== e_tx) begin errors++; $display("FAIL basic_tx got=%h exp=%h", c_tx, e_tx); end
    checks++; if (c_rdy !== e_rdy) begin errors++; $display("FAIL basic_ready got=%h exp=%h", c_rdy, e_rdy); end
    checks++; if (c_done !== e_done) begin errors++; $display("FAIL basic_done got=%h exp=%h", c_done, e_done); end
    checks++; if (c_busy !== (~e_rdy & m)) begin errors++; $display("FAIL basic_busy got=%h exp=%h", c_busy, ~e_rdy & m); end
    for (int k = 0; k < 9; k++) cells[k] = c_tx[k * CPB + 1];
    checks++; if (cells !== 9'h14A) begin errors++; $display("FAIL basic_cells got=%h exp=14a", cells); end
    checks++;
    if (c_done !== (128'd1 << FRAME0)) begin
      errors++; $display("FAIL basic_done_cycle got=%h exp=%h", c_done, 128'd1 << FRAME0);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    exp_clear(); exp_frame(8'h07, 1, 1'b0); exp_idle(2);
    d0 = 8'h07; v0 = 1'b1;
    capture(0, e_n, 1, 8'h07, 0);
    checks++; if (c_tx[37] !== 1'b1) begin errors++; $display("FAIL par_even_07 got=%b exp=1", c_tx[37]); end
    checks++; if (c_done !== (128'd1 << 44)) begin errors++; $display("FAIL par_len44 got=%h exp=%h", c_done, 128'd1 << 44); end
    checks++; if (c_tx !== e_tx) begin errors++; $display("FAIL par_07_tx got=%h exp=%h", c_tx, e_tx); end
    exp_clear(); exp_frame(8'h03, 1, 1'b0); exp_idle(2);
    d0 = 8'h03; v0 = 1'b1;
    capture(0, e_n, 1, 8'h03, 0);
    checks++; if (c_tx[37] !== 1'b0) begin errors++; $display("FAIL par_even_03 got=%b exp=0", c_tx[37]); end
    checks++; if (c_tx !== e_tx) begin errors++; $display("FAIL par_03_tx got=%h exp=%h", c_tx, e_tx); end
    exp_clear(); exp_frame(8'h03, 2, 1'b1); exp_idle(2);
    d1 = 8'h03; v1 = 1'b1;
    capture(1, e_n, 1, 8'h03, 0);
    checks++; if (c_tx[37] !== 1'b1) begin errors++; $display("FAIL par_odd_03 got=%b exp=1", c_tx[37]); end
    checks++; if (c_tx !== e_tx) begin errors++; $display("FAIL par_odd_tx got=%h exp=%h", c_tx, e_tx); end
  endtask
`endif

  task automatic test_back_to_back();
    exp_clear(); exp_frame(8'h55, 1, 1'b0); exp_frame(8'hFF, 1, 1'b0); exp_idle(4);
    d0 = 8'h55; v0 = 1'b1;
    capture(0, e_n, FRAME0 + 1, 8'hFF, 0);
    checks++; if (c_tx !== e_tx) begin errors++; $display("FAIL b2b_tx got=%h exp=%h", c_tx, e_tx); end
    checks++; if (c_rdy !== e_rdy) begin errors++; $display("FAIL b2b_ready got=%h exp=%h", c_rdy, e_rdy); end
    checks++; if (c_done !== e_done) begin errors++; $display("FAIL b2b_done got=%h exp=%h", c_done, e_done); end
    checks++;
    if ($countones(c_done) != 2) begin
      errors++; $display("FAIL b2b_done_count got=%0d exp=2", $countones(c_done));
    end
  endtask

  task automatic test_ignore();
    exp_clear(); exp_frame(8'h3C, 1, 1'b0); exp_idle(6);
    d0 = 8'h3C; v0 = 1'b1;
    capture(0, e_n, 1, 8'h3C, FRAME0);
    checks++; if (c_tx !== e_tx) begin errors++; $display("FAIL ignore_tx got=%h exp=%h", c_tx, e_tx); end
    checks++; if (c_rdy !== e_rdy) begin errors++; $display("FAIL ignore_ready got=%h exp=%h", c_rdy, e_rdy); end
    checks++; if (c_done !== e_done) begin errors++; $display("FAIL ignore_done got=%h exp=%h", c_done, e_done); end
    v0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [127:0] m;
    b = 8'($urandom);
    exp_clear(); exp_frame(b, 1, 1'b0);
    m = (128'd1 << 15) - 128'd1;
    d0 = b; v0 = 1'b1;
    capture(0, 15, 1, b, 0);
    checks++; if (c_tx !== (e_tx & m)) begin errors++; $display("FAIL midrst_prefix got=%h exp=%h", c_tx, e_tx & m); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx0, rdy0, busy0, done0} !== 4'b1100) begin
      errors++; $display("FAIL midrst_state got=%b exp=1100", {tx0, rdy0, busy0, done0});
    end
    reset = 1'b0;
    exp_clear(); exp_idle(50);
    capture(0, 50, 0, d0, 0);
    checks++; if (c_done !== e_done) begin errors++; $display("FAIL midrst_no_done got=%h exp=%h", c_done, e_done); end
    checks++; if (c_tx !== e_tx) begin errors++; $display("FAIL midrst_idle_tx got=%h exp=%h", c_tx, e_tx); end
    exp_clear(); exp_frame(8'h81, 1, 1'b0); exp_idle(2);
    d0 = 8'h81; v0 = 1'b1;
    capture(0, e_n, 1, 8'h81, 0);
    checks++; if (c_tx !== e_tx) begin errors++; $display("FAIL midrst_81_tx got=%h exp=%h", c_tx, e_tx); end
    checks++; if (c_done !== e_done) begin errors++; $display("FAIL midrst_81_done got=%h exp=%h", c_done, e_done); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int sel;
    for (int t = 0; t < 6; t++) begin
      b = 8'($urandom);
      sel = int'($urandom_range(1, 0));
      exp_clear(); exp_frame(b, (sel == 1) ? 2 : 1, (sel == 1) ? 1'b1 : 1'b0); exp_idle(2);
      if (sel == 0) begin d0 = b; v0 = 1'b1; end else begin d1 = b; v1 = 1'b1; end
      capture(sel, e_n, 1, b, 0);
      checks++;
      if (c_tx !== e_tx) begin errors++; $display("FAIL rand_tx sel=%0d byte=%h got=%h exp=%h", sel, b, c_tx, e_tx); end
      checks++;
      if (c_rdy !== e_rdy) begin errors++; $display("FAIL rand_ready sel=%0d got=%h exp=%h", sel, c_rdy, e_rdy); end
      checks++;
      if (c_done !== e_done) begin errors++; $display("FAIL rand_done sel=%0d got=%h exp=%h", sel, c_done, e_done); end
    end
  endtask

  // Behavioural receiver: mid-bit sampling of tx1 (2 stop bits, odd parity when enabled).
  task automatic rx_byte(output logic [7:0] b, output logic perr, output logic serr, output logic tmo);
    int k;
    logic p;
    b = 8'h00; perr = 1'b0; serr = 1'b0; tmo = 1'b0; k = 0;
    do begin
      @(negedge clk); k++;
    end while (tx1 !== 1'b0 && k < 100);
    if (k >= 100) tmo = 1'b1;
    @(negedge clk);
    if (tx1 !== 1'b0) serr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx1;
    end
    if (PEN == 1) begin
      repeat (CPB) @(negedge clk);
      p = tx1;
      if (p !== ((^b) ^ 1'b1)) perr = 1'b1;
    end
    for (int s = 0; s < 2; s++) begin
      repeat (CPB) @(negedge clk);
      if (tx1 !== 1'b1) serr = 1'b1;
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    logic [7:0] got;
    logic perr, serr, tmo, tmo_a;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
    for (int n = 0; n < 3; n++) begin
      tmo_a = 1'b0;
      fork
        begin
          int k;
          d1 = bytes[n]; v1 = 1'b1;
          @(negedge clk);
          v1 = 1'b0;
          k = 0;
          while (done1 !== 1'b1 && k < 100) begin @(negedge clk); k++; end
          if (k >= 100) tmo_a = 1'b1;
        end
        rx_byte(got, perr, serr, tmo);
      join
      checks++;
      if (got !== bytes[n]) begin errors++; $display("FAIL loop_data got=%h exp=%h", got, bytes[n]); end
      checks++;
      if ({tmo_a, tmo, perr, serr} !== 4'b0000) begin
        errors++; $display("FAIL loop_status byte=%h got tmo_a/tmo/perr/serr=%b exp=0000", bytes[n], {tmo_a, tmo, perr, serr});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_random();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
